// File: rtl/serial_adder_if.sv
// Handshake and operand/result bundle for the bit-serial adder.
// The master drives the request side; the slave (the adder) drives status and result.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-adder cell reused over WIDTH cycles, LSB first,
// with a start/busy/done handshake and registered sum/cout/ovf results.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input logic          clock,
    input logic          reset,
    serial_adder_if.slave bus
);
    localparam int            CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] s_sh;
    logic [WIDTH-1:0] s_next;
    logic [WIDTH-1:0] sum_q;
    logic             carry;
    logic             cout_q;
    logic             ovf_q;
    logic [CW-1:0]    cnt;
    logic             bit_s;
    logic             bit_c;
    logic             last_bit;

    // The single full-adder cell; the new sum bit enters the result shifter at the MSB.
    always_comb begin
        bit_s             = a_sh[0] ^ b_sh[0] ^ carry;
        bit_c             = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
        s_next            = s_sh >> 1;
        s_next[WIDTH-1]   = bit_s;
        last_bit          = (cnt == LAST);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (last_bit)  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // On the last bit the current carry is the carry into the MSB, so ovf is formed directly.
    always_ff @(posedge clock) begin
        if (reset) begin
            a_sh   <= '0;
            b_sh   <= '0;
            s_sh   <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sh  <= bus.a;
                        b_sh  <= bus.b;
                        carry <= bus.cin;
                        s_sh  <= '0;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    carry <= bit_c;
                    s_sh  <= s_next;
                    cnt   <= cnt + 1'b1;
                    if (last_bit) begin
                        sum_q  <= s_next;
                        cout_q <= bit_c;
                        ovf_q  <= carry ^ bit_c;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy = (state == RUN);
    assign bus.done = (state == DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH 8, 1 and 3, using a result scoreboard
// filled when an operation is launched and drained when done pulses.
module tb_serial_adder;
    typedef struct packed {
        logic        ovf;
        logic        cout;
        logic [31:0] sum;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   passed = 0;
    exp_t q8[$];
    exp_t q1[$];
    exp_t q3[$];

    always #5 clock = ~clock;

    serial_adder_if #(.WIDTH(8)) bus8 ();
    serial_adder_if #(.WIDTH(1)) bus1 ();
    serial_adder_if #(.WIDTH(3)) bus3 ();

    serial_adder #(.WIDTH(8)) dut8 (.clock(clock), .reset(reset), .bus(bus8));
    serial_adder #(.WIDTH(1)) dut1 (.clock(clock), .reset(reset), .bus(bus1));
    serial_adder #(.WIDTH(3)) dut3 (.clock(clock), .reset(reset), .bus(bus3));

    // Reference: full-width add, signed overflow from operand/result sign bits.
    function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                   input logic cin);
        logic [32:0] full;
        logic [31:0] mask;
        logic [31:0] am;
        logic [31:0] bm;
        exp_t        e;
        mask   = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        am     = a & mask;
        bm     = b & mask;
        full   = {1'b0, am} + {1'b0, bm} + {32'd0, cin};
        e.sum  = full[31:0] & mask;
        e.cout = full[w];
        e.ovf  = (am[w-1] == bm[w-1]) && (e.sum[w-1] != am[w-1]);
        return e;
    endfunction

    task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic cin);
        @(negedge clock);
        bus8.a     = a;
        bus8.b     = b;
        bus8.cin   = cin;
        bus8.start = 1'b1;
        q8.push_back(model(8, {24'd0, a}, {24'd0, b}, cin));
        @(negedge clock);
        bus8.start = 1'b0;
        bus8.a     = 8'($urandom);
        bus8.b     = 8'($urandom);
        bus8.cin   = 1'($urandom);
    endtask

    // Entered one negedge after the sampling edge; waits for done and checks the result.
    task automatic finish8(input string name);
        int   cyc;
        int   busy_n;
        exp_t e;
        cyc    = 0;
        busy_n = 0;
        while (bus8.done !== 1'b1 && cyc < 40) begin
            if (bus8.busy === 1'b1) busy_n++;
            cyc++;
            @(negedge clock);
        end
        checks++;
        if (cyc != 8) $display("[TB] FAIL %s latency: got %0d cycles, want 8", name, cyc);
        else passed++;
        checks++;
        if (busy_n != 8) $display("[TB] FAIL %s busy cycles: got %0d, want 8", name, busy_n);
        else passed++;
        checks++;
        if (bus8.done === 1'b1 && q8.size() > 0) begin
            e = q8.pop_front();
            if ({bus8.ovf, bus8.cout, bus8.sum} !== {e.ovf, e.cout, e.sum[7:0]})
                $display("[TB] FAIL %s result: got ovf=%b cout=%b sum=%h, want ovf=%b cout=%b sum=%h",
                         name, bus8.ovf, bus8.cout, bus8.sum, e.ovf, e.cout, e.sum[7:0]);
            else passed++;
        end else begin
            $display("[TB] FAIL %s result: got no done pulse, want done with queued result", name);
            if (q8.size() > 0) q8.delete(0);
        end
        @(negedge clock);
        checks++;
        if ({bus8.done, bus8.busy} !== 2'b00)
            $display("[TB] FAIL %s done pulse: got done=%b busy=%b after DONE, want 0 0",
                     name, bus8.done, bus8.busy);
        else passed++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        checks++;
        if ({bus8.busy, bus8.done, bus8.ovf, bus8.cout, bus8.sum} !== 12'h000)
            $display("[TB] FAIL reset w8: got busy=%b done=%b ovf=%b cout=%b sum=%h, want all 0",
                     bus8.busy, bus8.done, bus8.ovf, bus8.cout, bus8.sum);
        else passed++;
        checks++;
        if ({bus1.busy, bus1.done, bus1.ovf, bus1.cout, bus1.sum,
             bus3.busy, bus3.done, bus3.ovf, bus3.cout, bus3.sum} !== 12'h000)
            $display("[TB] FAIL reset w1/w3: got %b %b, want all 0",
                     {bus1.busy, bus1.done, bus1.ovf, bus1.cout, bus1.sum},
                     {bus3.busy, bus3.done, bus3.ovf, bus3.cout, bus3.sum});
        else passed++;
        reset = 1'b0;
    endtask

    task automatic test_basic();
        start8(8'h03, 8'h05, 1'b0);
        finish8("basic 03+05");
    endtask

    task automatic test_unsigned_wrap();
        start8(8'hFF, 8'h01, 1'b0);
        finish8("wrap FF+01");
        start8(8'hFF, 8'h00, 1'b1);
        finish8("wrap FF+00+1");
    endtask

    task automatic test_signed_overflow();
        start8(8'h7F, 8'h01, 1'b0);
        finish8("ovf 7F+01");
        start8(8'h80, 8'h80, 1'b0);
        finish8("ovf 80+80");
    endtask

    // A start pulse during RUN must be ignored and must not queue another operation.
    task automatic test_protocol();
        int         cyc;
        int         unstable;
        int         extra_done;
        logic [7:0] held;
        exp_t       e;
        start8(8'h11, 8'h22, 1'b0);
        held     = bus8.sum;
        unstable = 0;
        cyc      = 0;
        while (bus8.done !== 1'b1 && cyc < 40) begin
            if (cyc == 2) begin
                bus8.start = 1'b1;
                bus8.a     = 8'hF0;
                bus8.b     = 8'h0F;
                bus8.cin   = 1'b1;
            end else begin
                bus8.start = 1'b0;
            end
            if (bus8.sum !== held) unstable++;
            cyc++;
            @(negedge clock);
        end
        bus8.start = 1'b0;
        checks++;
        if (cyc != 8) $display("[TB] FAIL protocol latency: got %0d cycles, want 8", cyc);
        else passed++;
        checks++;
        if (unstable != 0) $display("[TB] FAIL protocol sum hold: got %0d changes during RUN, want 0", unstable);
        else passed++;
        checks++;
        if (bus8.done === 1'b1 && q8.size() > 0) begin
            e = q8.pop_front();
            if ({bus8.ovf, bus8.cout, bus8.sum} !== {e.ovf, e.cout, e.sum[7:0]})
                $display("[TB] FAIL protocol result: got ovf=%b cout=%b sum=%h, want ovf=%b cout=%b sum=%h",
                         bus8.ovf, bus8.cout, bus8.sum, e.ovf, e.cout, e.sum[7:0]);
            else passed++;
        end else begin
            $display("[TB] FAIL protocol result: got no done pulse, want done");
            if (q8.size() > 0) q8.delete(0);
        end
        extra_done = 0;
        repeat (12) begin
            @(negedge clock);
            if (bus8.done === 1'b1 || bus8.busy === 1'b1) extra_done++;
        end
        checks++;
        if (extra_done != 0) $display("[TB] FAIL protocol no requeue: got %0d active cycles, want 0", extra_done);
        else passed++;
    endtask

    // start held high relaunches on each IDLE cycle, sampling whatever a/b/cin are then.
    task automatic test_back_to_back();
        @(negedge clock);
        bus8.a     = 8'h12;
        bus8.b     = 8'h34;
        bus8.cin   = 1'b1;
        bus8.start = 1'b1;
        q8.push_back(model(8, 32'h12, 32'h34, 1'b1));
        @(negedge clock);
        bus8.a   = 8'hA5;
        bus8.b   = 8'h5A;
        bus8.cin = 1'b0;
        q8.push_back(model(8, 32'hA5, 32'h5A, 1'b0));
        finish8("b2b first");
        @(negedge clock);
        checks++;
        if (bus8.busy !== 1'b1) $display("[TB] FAIL b2b relaunch: got busy=%b, want 1", bus8.busy);
        else passed++;
        bus8.start = 1'b0;
        finish8("b2b second");
    endtask

    task automatic test_reset_mid_op();
        int extra_done;
        start8(8'h10, 8'h20, 1'b0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        q8.delete();
        checks++;
        if ({bus8.busy, bus8.done, bus8.ovf, bus8.cout, bus8.sum} !== 12'h000)
            $display("[TB] FAIL reset mid-op: got busy=%b done=%b ovf=%b cout=%b sum=%h, want all 0",
                     bus8.busy, bus8.done, bus8.ovf, bus8.cout, bus8.sum);
        else passed++;
        extra_done = 0;
        repeat (15) begin
            @(negedge clock);
            if (bus8.done === 1'b1) extra_done++;
        end
        checks++;
        if (extra_done != 0) $display("[TB] FAIL reset abort: got %0d done pulses, want 0", extra_done);
        else passed++;
        start8(8'h64, 8'h64, 1'b1);
        finish8("after reset 64+64+1");
    endtask

    task automatic test_exhaustive();
        int         cyc;
        logic [2:0] v1;
        logic [6:0] v3;
        exp_t       e;
        for (int v = 0; v < 8; v++) begin
            v1 = 3'(v);
            @(negedge clock);
            bus1.a     = v1[2];
            bus1.b     = v1[1];
            bus1.cin   = v1[0];
            bus1.start = 1'b1;
            q1.push_back(model(1, {31'd0, v1[2]}, {31'd0, v1[1]}, v1[0]));
            @(negedge clock);
            bus1.start = 1'b0;
            cyc = 0;
            while (bus1.done !== 1'b1 && cyc < 20) begin
                cyc++;
                @(negedge clock);
            end
            e = q1.pop_front();
            checks++;
            if (bus1.done !== 1'b1 || cyc != 1 ||
                {bus1.ovf, bus1.cout, bus1.sum} !== {e.ovf, e.cout, e.sum[0]})
                $display("[TB] FAIL w1 {a,b,cin}=%b: got done=%b lat=%0d ovf=%b cout=%b sum=%b, want lat=1 ovf=%b cout=%b sum=%b",
                         v1, bus1.done, cyc, bus1.ovf, bus1.cout, bus1.sum, e.ovf, e.cout, e.sum[0]);
            else passed++;
            @(negedge clock);
        end
        for (int v = 0; v < 128; v++) begin
            v3 = 7'(v);
            @(negedge clock);
            bus3.a     = v3[6:4];
            bus3.b     = v3[3:1];
            bus3.cin   = v3[0];
            bus3.start = 1'b1;
            q3.push_back(model(3, {29'd0, v3[6:4]}, {29'd0, v3[3:1]}, v3[0]));
            @(negedge clock);
            bus3.start = 1'b0;
            cyc = 0;
            while (bus3.done !== 1'b1 && cyc < 20) begin
                cyc++;
                @(negedge clock);
            end
            e = q3.pop_front();
            checks++;
            if (bus3.done !== 1'b1 || cyc != 3 ||
                {bus3.ovf, bus3.cout, bus3.sum} !== {e.ovf, e.cout, e.sum[2:0]})
                $display("[TB] FAIL w3 {a,b,cin}=%b: got done=%b lat=%0d ovf=%b cout=%b sum=%h, want lat=3 ovf=%b cout=%b sum=%h",
                         v3, bus3.done, cyc, bus3.ovf, bus3.cout, bus3.sum, e.ovf, e.cout, e.sum[2:0]);
            else passed++;
            @(negedge clock);
        end
    endtask

    initial begin
        bus8.start = 1'b0;
        bus8.a     = '0;
        bus8.b     = '0;
        bus8.cin   = 1'b0;
        bus1.start = 1'b0;
        bus1.a     = '0;
        bus1.b     = '0;
        bus1.cin   = 1'b0;
        bus3.start = 1'b0;
        bus3.a     = '0;
        bus3.b     = '0;
        bus3.cin   = 1'b0;
        test_reset();
        test_basic();
        test_unsigned_wrap();
        test_signed_overflow();
        test_protocol();
        test_back_to_back();
        test_reset_mid_op();
        test_exhaustive();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
